// File: rtl/add_num_operand_fetch_if.sv
// Bundle of the operand-fetch stage's handshake and CCI-P c0 read signals.
//   start_*   : fetch request from the AFU control logic
//   rd_req_*  : c0 read request toward the host, plus c0_tx_alm_full backpressure
//   rd_rsp_*  : c0 read responses (read responses only)
//   op_*      : operand handoff to the add/write state machine
//   timeout   : one-cycle pulse when a request is abandoned
//   stale_cnt : saturating count of dropped responses
// modport master is the fetch stage itself; modport slave is its environment.
interface add_num_operand_fetch_if #(
    parameter int unsigned ADDR_W = 42,
    parameter int unsigned DATA_W = 512
) ();
    logic              start_valid;
    logic [ADDR_W-1:0] start_addr;
    logic              start_ready;

    logic              rd_req_valid;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [15:0]       rd_req_mdata;
    logic              c0_tx_alm_full;

    logic              rd_rsp_valid;
    logic [15:0]       rd_rsp_mdata;
    logic [DATA_W-1:0] rd_rsp_data;

    logic              op_valid;
    logic [7:0]        op_a;
    logic [7:0]        op_b;
    logic              op_ready;

    logic              timeout;
    logic [7:0]        stale_cnt;

    modport master (
        input  start_valid, start_addr, c0_tx_alm_full,
        input  rd_rsp_valid, rd_rsp_mdata, rd_rsp_data, op_ready,
        output start_ready, rd_req_valid, rd_req_addr, rd_req_mdata,
        output op_valid, op_a, op_b, timeout, stale_cnt
    );

    modport slave (
        output start_valid, start_addr, c0_tx_alm_full,
        output rd_rsp_valid, rd_rsp_mdata, rd_rsp_data, op_ready,
        input  start_ready, rd_req_valid, rd_req_addr, rd_req_mdata,
        input  op_valid, op_a, op_b, timeout, stale_cnt
    );
endinterface

// File: rtl/add_num_operand_fetch.sv
// Operand fetch stage for the add-two-numbers AFU.
// Issues one tagged CCI-P c0 read per start, waits for the matching response,
// and presents line[7:0] / line[15:8] as op_a / op_b over a valid/ready handshake.
// Non-matching responses are dropped and counted; a watchdog abandons a lost read.
// Ports:
//   clk   : host_ccip.clk
//   reset : synchronous, active-high
//   bus   : add_num_operand_fetch_if.master (start, c0 request/response, operands,
//           timeout pulse, stale response counter)
module add_num_operand_fetch #(
    parameter int unsigned ADDR_W      = 42,
    parameter int unsigned DATA_W      = 512,
    parameter logic [15:0] MDATA_BASE  = 16'hA0D0,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic                     clk,
    input logic                     reset,
    add_num_operand_fetch_if.master bus
);
    localparam int unsigned WdW = $clog2(TIMEOUT_CYC);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       tag_q, tag_d;
    logic [3:0]        seq_q, seq_d;
    logic [WdW-1:0]    wd_q, wd_d;
    logic [7:0]        stale_q, stale_d;
    logic [7:0]        op_a_q, op_a_d;
    logic [7:0]        op_b_q, op_b_d;
    logic              req_valid_q, req_valid_d;
    logic              timeout_q, timeout_d;
    logic              ready_q, ready_d;
    logic              match;

    // Only the low 16 bits of the line carry operands.
    logic unused_rsp_bits;
    assign unused_rsp_bits = ^bus.rd_rsp_data[DATA_W-1:16];

    // tag_q holds the tag of the single outstanding request.
    assign match = (state_q == StWait) && bus.rd_rsp_valid && (bus.rd_rsp_mdata == tag_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tag_d       = tag_q;
        seq_d       = seq_q;
        wd_d        = wd_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        req_valid_d = 1'b0;
        timeout_d   = 1'b0;
        stale_d     = stale_q;

        if (bus.rd_rsp_valid && !match && (stale_q != 8'hFF)) begin
            stale_d = stale_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start_valid && ready_q) begin
                    addr_d  = bus.start_addr;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (!bus.c0_tx_alm_full) begin
                    req_valid_d = 1'b1;
                    tag_d       = {MDATA_BASE[15:4], seq_q};
                    seq_d       = seq_q + 4'd1;
                    wd_d        = '0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                // A match on the last watchdog cycle still wins over the timeout.
                if (match) begin
                    op_a_d  = bus.rd_rsp_data[7:0];
                    op_b_d  = bus.rd_rsp_data[15:8];
                    state_d = StOut;
                end else if (wd_q == WdLast) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StOut: begin
                if (bus.op_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered so start_ready stays low while reset is held.
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            tag_q       <= '0;
            seq_q       <= '0;
            wd_q        <= '0;
            stale_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            req_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            tag_q       <= tag_d;
            seq_q       <= seq_d;
            wd_q        <= wd_d;
            stale_q     <= stale_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            req_valid_q <= req_valid_d;
            timeout_q   <= timeout_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.start_ready  = ready_q;
    assign bus.rd_req_valid = req_valid_q;
    assign bus.rd_req_addr  = addr_q;
    assign bus.rd_req_mdata = tag_q;
    assign bus.op_valid     = (state_q == StOut);
    assign bus.op_a         = op_a_q;
    assign bus.op_b         = op_b_q;
    assign bus.timeout      = timeout_q;
    assign bus.stale_cnt    = stale_q;
endmodule

// File: tb/tb_add_num_operand_fetch.sv
// Directed self-checking bench for add_num_operand_fetch (TIMEOUT_CYC = 8).
module tb_add_num_operand_fetch;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    add_num_operand_fetch_if #(.ADDR_W(42), .DATA_W(512)) bus ();

    add_num_operand_fetch #(
        .ADDR_W     (42),
        .DATA_W     (512),
        .MDATA_BASE (16'hA0D0),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [41:0] addr);
        bus.start_valid = 1'b1;
        bus.start_addr  = addr;
        step();
        bus.start_valid = 1'b0;
    endtask

    task automatic send_rsp(input logic [15:0] tag, input logic [15:0] line);
        bus.rd_rsp_valid = 1'b1;
        bus.rd_rsp_mdata = tag;
        bus.rd_rsp_data  = {{496{1'b1}}, line};
        step();
        bus.rd_rsp_valid = 1'b0;
    endtask

    // Full fetch: start, request pulse, matching response, immediate handshake.
    task automatic fetch(input logic [41:0] addr, input logic [15:0] line,
                         input logic [15:0] exp_tag);
        do_start(addr);
        step();
        check("fetch_req_valid", bus.rd_req_valid, 1);
        check("fetch_req_addr", bus.rd_req_addr, addr);
        check("fetch_req_tag", bus.rd_req_mdata, exp_tag);
        send_rsp(exp_tag, line);
        check("fetch_op_valid", bus.op_valid, 1);
        check("fetch_op_a", bus.op_a, line[7:0]);
        check("fetch_op_b", bus.op_b, line[15:8]);
        bus.op_ready = 1'b1;
        step();
        bus.op_ready = 1'b0;
        check("fetch_op_drop", bus.op_valid, 0);
        check("fetch_ready", bus.start_ready, 1);
    endtask

    initial begin
        logic [15:0] exp_tag;
        checks   = 0;
        failures = 0;
        reset               = 1'b1;
        bus.start_valid     = 1'b0;
        bus.start_addr      = '0;
        bus.c0_tx_alm_full  = 1'b0;
        bus.rd_rsp_valid    = 1'b0;
        bus.rd_rsp_mdata    = '0;
        bus.rd_rsp_data     = '0;
        bus.op_ready        = 1'b0;

        // Reset state
        step(); step(); step();
        check("rst_ready_in_reset", bus.start_ready, 0);
        reset = 1'b0;
        step();
        check("rst_ready", bus.start_ready, 1);
        check("rst_req_valid", bus.rd_req_valid, 0);
        check("rst_op_valid", bus.op_valid, 0);
        check("rst_timeout", bus.timeout, 0);
        check("rst_op_a", bus.op_a, 0);
        check("rst_op_b", bus.op_b, 0);
        check("rst_req_addr", bus.rd_req_addr, 0);
        check("rst_req_mdata", bus.rd_req_mdata, 0);
        check("rst_stale", bus.stale_cnt, 0);

        // Basic fetch: response three cycles after the request
        do_start(42'h100);
        check("basic_req_early", bus.rd_req_valid, 0);
        check("basic_busy", bus.start_ready, 0);
        step();
        check("basic_req_valid", bus.rd_req_valid, 1);
        check("basic_req_addr", bus.rd_req_addr, 42'h100);
        check("basic_req_tag", bus.rd_req_mdata, 16'hA0D0);
        step();
        check("basic_req_pulse", bus.rd_req_valid, 0);
        step(); step();
        check("basic_no_op_yet", bus.op_valid, 0);
        send_rsp(16'hA0D0, 16'h0503);
        check("basic_op_valid", bus.op_valid, 1);
        check("basic_op_a", bus.op_a, 8'h03);
        check("basic_op_b", bus.op_b, 8'h05);
        bus.op_ready = 1'b1;
        step();
        bus.op_ready = 1'b0;
        check("basic_op_drop", bus.op_valid, 0);
        check("basic_ready", bus.start_ready, 1);

        // Backpressure on the request, then on the operands
        bus.c0_tx_alm_full = 1'b1;
        do_start(42'h2A0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_no_req", bus.rd_req_valid, 0);
        end
        bus.c0_tx_alm_full = 1'b0;
        step();
        check("bp_req_valid", bus.rd_req_valid, 1);
        check("bp_req_tag", bus.rd_req_mdata, 16'hA0D1);
        check("bp_req_addr", bus.rd_req_addr, 42'h2A0);
        send_rsp(16'hA0D1, 16'h7F80);
        check("bp_req_once", bus.rd_req_valid, 0);
        for (int i = 0; i < 4; i++) begin
            bus.rd_rsp_data = {32{16'h5A5A}};
            check("bp_hold_valid", bus.op_valid, 1);
            check("bp_hold_a", bus.op_a, 8'h80);
            check("bp_hold_b", bus.op_b, 8'h7F);
            step();
        end
        check("bp_still_valid", bus.op_valid, 1);
        bus.op_ready = 1'b1;
        step();
        bus.op_ready = 1'b0;
        check("bp_op_drop", bus.op_valid, 0);
        check("bp_ready", bus.start_ready, 1);

        // Foreign tag in WAIT, start ignored outside IDLE, then a response in IDLE
        do_start(42'h300);
        step();
        check("stale_req_tag", bus.rd_req_mdata, 16'hA0D2);
        bus.start_valid = 1'b1;
        bus.start_addr  = 42'h3DEAD;
        send_rsp(16'h1234, 16'hFFFF);
        bus.start_valid = 1'b0;
        check("stale_cnt1", bus.stale_cnt, 1);
        check("stale_no_op", bus.op_valid, 0);
        check("stale_addr_kept", bus.rd_req_addr, 42'h300);
        send_rsp(16'hA0D2, 16'h0201);
        check("stale_op_valid", bus.op_valid, 1);
        check("stale_op_a", bus.op_a, 8'h01);
        check("stale_op_b", bus.op_b, 8'h02);
        check("stale_cnt_keep", bus.stale_cnt, 1);
        bus.op_ready = 1'b1;
        step();
        bus.op_ready = 1'b0;
        send_rsp(16'hA0D2, 16'h0201);
        check("stale_idle_cnt2", bus.stale_cnt, 2);
        check("stale_idle_no_op", bus.op_valid, 0);

        // Timeout: pulse 8 cycles after the request
        do_start(42'h400);
        step();
        check("to_req_tag", bus.rd_req_mdata, 16'hA0D3);
        for (int i = 1; i < 8; i++) begin
            step();
            check("to_not_yet", bus.timeout, 0);
        end
        step();
        check("to_pulse", bus.timeout, 1);
        check("to_ready", bus.start_ready, 1);
        check("to_no_op", bus.op_valid, 0);
        step();
        check("to_pulse_once", bus.timeout, 0);
        do_start(42'h500);
        step();
        check("to_next_tag", bus.rd_req_mdata, 16'hA0D4);
        send_rsp(16'hA0D3, 16'hEEEE);
        check("to_late_stale", bus.stale_cnt, 3);
        check("to_late_no_op", bus.op_valid, 0);
        send_rsp(16'hA0D4, 16'h1122);
        check("to_next_op_a", bus.op_a, 8'h22);
        check("to_next_op_b", bus.op_b, 8'h11);
        check("to_next_op_valid", bus.op_valid, 1);
        bus.op_ready = 1'b1;
        step();
        bus.op_ready = 1'b0;

        // Match on the final watchdog cycle beats the timeout
        do_start(42'h600);
        step();
        check("edge_req_tag", bus.rd_req_mdata, 16'hA0D5);
        for (int i = 0; i < 7; i++) step();
        check("edge_no_to_yet", bus.timeout, 0);
        send_rsp(16'hA0D5, 16'h9988);
        check("edge_op_valid", bus.op_valid, 1);
        check("edge_no_timeout", bus.timeout, 0);
        check("edge_op_a", bus.op_a, 8'h88);
        bus.op_ready = 1'b1;
        step();
        bus.op_ready = 1'b0;
        check("edge_after_no_to", bus.timeout, 0);

        // Sequence wrap: fetches 7..16 then the 17th reuses tag A0D0
        for (int i = 6; i < 16; i++) begin
            exp_tag = 16'hA0D0 | 16'(i);
            fetch(42'h1000 + 42'(i), 16'(16'h0101 * i), exp_tag);
        end
        fetch(42'h2000, 16'hC3B4, 16'hA0D0);

        // Stale counter saturation
        bus.rd_rsp_valid = 1'b1;
        bus.rd_rsp_mdata = 16'hBEEF;
        for (int i = 0; i < 300; i++) step();
        bus.rd_rsp_valid = 1'b0;
        check("sat_stale", bus.stale_cnt, 255);
        step();
        check("sat_hold", bus.stale_cnt, 255);

        // Reset in WAIT abandons the request; its response is then stale
        do_start(42'h700);
        step();
        check("rw_req_tag", bus.rd_req_mdata, 16'hA0D1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("rw_ready", bus.start_ready, 1);
        check("rw_stale_clr", bus.stale_cnt, 0);
        check("rw_no_op", bus.op_valid, 0);
        send_rsp(16'hA0D1, 16'h4455);
        check("rw_old_stale", bus.stale_cnt, 1);
        check("rw_old_no_op", bus.op_valid, 0);
        fetch(42'h800, 16'h3344, 16'hA0D0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
